// File: rtl/mold_arbiter.sv
// Round-robin share of one mold unit among N requesters; tags track in-flight ops.
// Request-to-response latency LATENCY+2; a held response blocks only its own slot.
module mold_arbiter #(
  parameter int N       = 4,
  parameter int LATENCY = 2,
  parameter int IDW     = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_valid,
  output logic [N-1:0]    req_ready,
  input  logic [20*N-1:0] req_x,
  input  logic [20*N-1:0] req_y,
  input  logic [20*N-1:0] req_z,
  output logic [N-1:0]    rsp_valid,
  input  logic [N-1:0]    rsp_ready,
  output logic [20*N-1:0] rsp_mold,
  output logic [19:0]     mold_x,
  output logic [19:0]     mold_y,
  output logic [19:0]     mold_z,
  input  logic [19:0]     mold_in,
  output logic            busy
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PEND = 2'd1, S_DONE = 2'd2} slot_t;

  slot_t          slot_q [N];
  slot_t          slot_d [N];
  logic [IDW-1:0] ptr_q;
  logic           gnt_vld;
  logic [IDW-1:0] gnt_idx;
  logic [IDW-1:0] cand;
  logic [19:0]    op_x, op_y, op_z;
  logic [LATENCY:0] tag_vld_q;
  logic [IDW-1:0] tag_id_q [LATENCY+1];
  logic [19:0]    rsp_q [N];
  logic           cap_vld;
  logic [IDW-1:0] cap_id;

  // The tag at the last stage lines up with the cycle the unit drives its result.
  assign cap_vld = tag_vld_q[LATENCY];
  assign cap_id  = tag_id_q[LATENCY];

  always_comb begin
    gnt_vld   = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    req_ready = '0;
    for (int o = 0; o < N; o++) begin
      cand = IDW'((int'(ptr_q) + o) % N);
      if (!gnt_vld && req_valid[cand] && slot_q[cand] == S_IDLE) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    if (gnt_vld) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    op_x = '0;
    op_y = '0;
    op_z = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_vld && gnt_idx == IDW'(i)) begin
        op_x = req_x[20*i +: 20];
        op_y = req_y[20*i +: 20];
        op_z = req_z[20*i +: 20];
      end
    end
  end

  always_comb begin
    busy      = |tag_vld_q;
    rsp_valid = '0;
    rsp_mold  = '0;
    for (int i = 0; i < N; i++) begin
      slot_d[i]          = slot_q[i];
      rsp_valid[i]       = (slot_q[i] == S_DONE);
      rsp_mold[20*i +: 20] = rsp_q[i];
      if (slot_q[i] == S_PEND) busy = 1'b1;
      case (slot_q[i])
        S_IDLE:  if (gnt_vld && gnt_idx == IDW'(i)) slot_d[i] = S_PEND;
        S_PEND:  if (cap_vld && cap_id == IDW'(i))  slot_d[i] = S_DONE;
        S_DONE:  if (rsp_ready[i])                  slot_d[i] = S_IDLE;
        default: slot_d[i] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      mold_x    <= '0;
      mold_y    <= '0;
      mold_z    <= '0;
      tag_vld_q <= '0;
      for (int s = 0; s <= LATENCY; s++) tag_id_q[s] <= '0;
      for (int i = 0; i < N; i++) begin
        slot_q[i] <= S_IDLE;
        rsp_q[i]  <= '0;
      end
    end else begin
      if (gnt_vld) ptr_q <= (gnt_idx == IDW'(N-1)) ? '0 : gnt_idx + 1'b1;
      mold_x    <= op_x;
      mold_y    <= op_y;
      mold_z    <= op_z;
      tag_vld_q <= {tag_vld_q[LATENCY-1:0], gnt_vld};
      tag_id_q[0] <= gnt_idx;
      for (int s = 1; s <= LATENCY; s++) tag_id_q[s] <= tag_id_q[s-1];
      for (int i = 0; i < N; i++) slot_q[i] <= slot_d[i];
      if (cap_vld && slot_q[cap_id] == S_PEND) rsp_q[cap_id] <= mold_in;
    end
  end

endmodule

// File: tb/tb_mold_arbiter.sv
// Scoreboard bench for mold_arbiter with a 2-cycle sqrt unit model behind it.
module tb_mold_arbiter;
  localparam int N   = 4;
  localparam int LAT = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [20*N-1:0] req_x = '0, req_y = '0, req_z = '0;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready = '1;
  logic [20*N-1:0] rsp_mold;
  logic [19:0]     mold_x, mold_y, mold_z;
  logic [19:0]     mold_in = '0, u1 = '0;
  logic            busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {logic [19:0] val; int cyc;} exp_t;
  exp_t        rq [N][$];
  int          gq [$];
  logic [19:0] exp_val [N];
  logic [N-1:0] hold = '0;
  int          last_gnt [N];
  int          last_rsp [N];
  logic        chk_ops = 1'b0;
  logic [19:0] ex = '0, ey = '0, ez = '0;
  logic [19:0] cur_exp [N];
  logic [N-1:0] prev_vld = '0;

  mold_arbiter #(.N(N), .LATENCY(LAT), .IDW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_z(req_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_mold(rsp_mold),
    .mold_x(mold_x), .mold_y(mold_y), .mold_z(mold_z),
    .mold_in(mold_in), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint isqrt(input longint v);
    longint r;
    r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  // Unit model: result appears on mold_in two cycles after operands are presented.
  always @(posedge clk) begin
    u1      <= 20'(isqrt(longint'(mold_x) * longint'(mold_x) +
                         longint'(mold_y) * longint'(mold_y) +
                         longint'(mold_z) * longint'(mold_z)));
    mold_in <= u1;
  end

  function automatic logic [19:0] lane(input logic [20*N-1:0] v, input int i);
    return 20'(v >> (20 * i));
  endfunction

  function automatic logic [20*N-1:0] put(input logic [20*N-1:0] v, input int i, input int d);
    logic [20*N-1:0] m;
    m = {{(20*N-20){1'b0}}, 20'hFFFFF} << (20 * i);
    return (v & ~m) | (({{(20*N-20){1'b0}}, 20'(d)}) << (20 * i));
  endfunction

  task automatic check(input logic ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic req(input int i, input int x, input int y, input int z, input int e);
    req_x = put(req_x, i, x);
    req_y = put(req_y, i, y);
    req_z = put(req_z, i, z);
    exp_val[i] = 20'(e);
    req_valid[i] = 1'b1;
  endtask

  task automatic tick();
    logic [N-1:0] hs;
    int g;
    @(negedge clk);
    hs = req_valid & req_ready;
    if (chk_ops) begin
      check(mold_x == ex, "mold_x", longint'(mold_x), longint'(ex));
      check(mold_y == ey, "mold_y", longint'(mold_y), longint'(ey));
      check(mold_z == ez, "mold_z", longint'(mold_z), longint'(ez));
    end
    check($countones(req_ready) <= 1, "one_grant", longint'($countones(req_ready)), 1);
    ex = '0; ey = '0; ez = '0;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        if (gq.size() > 0) begin
          g = gq.pop_front();
          check(g == i, "grant_order", longint'(i), longint'(g));
        end
        check(last_rsp[i] > last_gnt[i] && last_rsp[i] < cyc, "grant_legal",
              longint'(cyc), longint'(last_rsp[i] + 1));
        last_gnt[i] = cyc;
        rq[i].push_back('{val: exp_val[i], cyc: cyc});
        ex = lane(req_x, i); ey = lane(req_y, i); ez = lane(req_z, i);
      end
    end
    chk_ops = rst_n;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~(hs & ~hold);
  endtask

  // Monitor: pops the scoreboard when a response first appears, then checks it holds.
  initial begin
    exp_t e;
    for (int i = 0; i < N; i++) begin
      last_rsp[i] = 0;
      cur_exp[i]  = '0;
    end
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int i = 0; i < N; i++) begin
          rq[i].delete();
          last_rsp[i] = cyc;
        end
        prev_vld = '0;
      end else begin
        if (dut.tag_vld_q[LAT]) begin
          checks++;
          assert (dut.slot_q[dut.tag_id_q[LAT]] == 2'd1)
          else begin
            errors++;
            $display("FAIL tag_exit: tag for slot %0d exits while slot not pending", dut.tag_id_q[LAT]);
          end
        end
        for (int i = 0; i < N; i++) begin
          if (rsp_valid[i]) begin
            if (!prev_vld[i]) begin
              if (rq[i].size() == 0) begin
                check(1'b0, "spurious_rsp", longint'(i), -1);
              end else begin
                e = rq[i].pop_front();
                cur_exp[i] = e.val;
                check(lane(rsp_mold, i) == e.val, "rsp_value",
                      longint'(lane(rsp_mold, i)), longint'(e.val));
                check(cyc == e.cyc + LAT + 2, "rsp_latency",
                      longint'(cyc - e.cyc), longint'(LAT + 2));
              end
            end else begin
              check(lane(rsp_mold, i) == cur_exp[i], "rsp_hold",
                    longint'(lane(rsp_mold, i)), longint'(cur_exp[i]));
            end
            if (rsp_ready[i]) last_rsp[i] = cyc;
          end
          prev_vld[i] = rsp_valid[i] & ~rsp_ready[i];
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      last_gnt[i] = -1;
      exp_val[i]  = '0;
    end
    #2;
    check(rsp_valid == '0, "rst_rsp_valid", longint'(rsp_valid), 0);
    check(busy == 1'b0, "rst_busy", longint'(busy), 0);
    check(mold_x == '0 && mold_y == '0 && mold_z == '0, "rst_mold", longint'(mold_x), 0);
    check(rsp_mold == '0, "rst_rsp_mold", longint'(lane(rsp_mold, 0)), 0);
    check(req_ready == '0, "rst_req_ready", longint'(req_ready), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single request, response held until consumed
    rsp_ready[0] = 1'b0;
    req(0, 3, 4, 0, 5); gq.push_back(0);
    tick();
    check(busy == 1'b1, "busy_inflight", longint'(busy), 1);
    repeat (8) tick();
    rsp_ready[0] = 1'b1;
    repeat (2) tick();
    check(busy == 1'b0, "busy_drained", longint'(busy), 0);

    // Move pointer back to 0
    req(3, 3, 4, 12, 13); gq.push_back(3);
    repeat (7) tick();

    // All four at once
    req(0, 1, 2, 2, 3); req(1, 0, 0, 0, 0); req(2, 2, 3, 6, 7); req(3, 4, 4, 7, 9);
    gq.push_back(0); gq.push_back(1); gq.push_back(2); gq.push_back(3);
    repeat (10) tick();
    check(gq.size() == 0, "all4_grants", longint'(gq.size()), 0);

    // Fairness between 0 and 2
    hold[0] = 1'b1; hold[2] = 1'b1;
    req(0, 5, 12, 0, 13); req(2, 0, 3, 4, 5);
    for (int k = 0; k < 3; k++) begin
      gq.push_back(0); gq.push_back(2);
    end
    repeat (12) tick();
    hold = '0;
    req_valid = '0;
    repeat (8) tick();
    check(gq.size() == 0, "fair_grants", longint'(gq.size()), 0);

    // Backpressure on slot 1 while 3 and 0 proceed
    rsp_ready[1] = 1'b0; hold[1] = 1'b1;
    req(1, 6, 8, 0, 10); gq.push_back(1);
    tick();
    req(3, 9, 12, 20, 25); req(0, 0, 0, 7, 7);
    gq.push_back(3); gq.push_back(0);
    repeat (14) tick();
    check(req_ready[1] == 1'b0, "bp_no_regrant", longint'(req_ready[1]), 0);
    check(rsp_valid[1] == 1'b1, "bp_rsp_held", longint'(rsp_valid[1]), 1);
    rsp_ready[1] = 1'b1; gq.push_back(1);
    tick();
    hold[1] = 1'b0;
    tick();
    check(gq.size() == 0, "bp_regrant_next", longint'(gq.size()), 0);
    repeat (8) tick();

    // Wrap-around from pointer 3
    req(2, 3, 0, 4, 5); gq.push_back(2);
    repeat (7) tick();
    req(3, 0, 6, 8, 10); req(0, 2, 10, 11, 15);
    gq.push_back(3); gq.push_back(0);
    repeat (8) tick();
    req(0, 1, 0, 0, 1); req(1, 0, 1, 0, 1);
    gq.push_back(1); gq.push_back(0);
    repeat (8) tick();
    check(gq.size() == 0, "wrap_grants", longint'(gq.size()), 0);

    // Reset with an operation in flight
    req(0, 8, 0, 6, 10);
    tick();
    tick();
    rst_n = 1'b0; chk_ops = 1'b0;
    #1;
    check(rsp_valid == '0, "mid_rst_rsp_valid", longint'(rsp_valid), 0);
    check(busy == 1'b0, "mid_rst_busy", longint'(busy), 0);
    check(rsp_mold == '0, "mid_rst_rsp_mold", longint'(lane(rsp_mold, 0)), 0);
    check(mold_x == '0 && mold_z == '0, "mid_rst_mold", longint'(mold_x), 0);
    tick();
    rst_n = 1'b1;
    repeat (8) tick();
    check(rsp_valid == '0, "post_rst_no_rsp", longint'(rsp_valid), 0);
    check(busy == 1'b0, "post_rst_idle", longint'(busy), 0);

    for (int i = 0; i < N; i++)
      check(rq[i].size() == 0, "rsp_missing", longint'(rq[i].size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
